// File: rtl/hx711_slave.sv
// hx711_slave: emulates the HX711 24-bit load-cell ADC serial interface.
// A parallel load port supplies conversion results; the master clocks them
// out MSB-first on pd_sck/dout and selects gain with 25/26/27 pulses.
module hx711_slave #(
    parameter int unsigned CONV_CYCLES = 5000,
    parameter int unsigned PD_CYCLES   = 3000,
    parameter int unsigned TAIL_IDLE   = 128
) (
    input  logic        clk_50,
    input  logic        rst,
    input  logic        pd_sck,
    output logic        dout,
    input  logic [23:0] sample_data,
    input  logic        sample_valid,
    output logic [1:0]  gain_sel,
    output logic        frame_done,
    output logic        powered_down
);

    localparam int unsigned DATA_W = 24;
    localparam int unsigned CNT_W  = 5;
    localparam int unsigned CONV_W = $clog2(CONV_CYCLES + 1);
    localparam int unsigned PD_W   = $clog2(PD_CYCLES + 1);
    localparam int unsigned IDLE_W = $clog2(TAIL_IDLE + 1);

    localparam logic [CNT_W-1:0]  PULSE_LAST_BIT = CNT_W'(24);
    localparam logic [CNT_W-1:0]  PULSE_BASE     = CNT_W'(25);
    localparam logic [CNT_W-1:0]  PULSE_MAX      = CNT_W'(27);
    localparam logic [CONV_W-1:0] CONV_LAST      = CONV_W'(CONV_CYCLES - 1);
    localparam logic [PD_W-1:0]   PD_LAST        = PD_W'(PD_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST      = IDLE_W'(TAIL_IDLE - 1);

    typedef enum logic [2:0] {
        ST_CONVERT,
        ST_READY,
        ST_SHIFT,
        ST_TAIL,
        ST_PWRDN
    } state_t;

    state_t              state,      state_n;
    logic                dout_n;
    logic [1:0]          gain_n;
    logic                done_n;
    logic                pwrdn_n;
    logic [DATA_W-1:0]   pending,    pending_n;
    logic [DATA_W-1:0]   shift_q,    shift_n;
    logic [CNT_W-1:0]    pulse_cnt,  pulse_n;
    logic [CONV_W-1:0]   conv_cnt,   conv_n;
    logic [PD_W-1:0]     hi_cnt,     hi_n;
    logic [IDLE_W-1:0]   idle_cnt,   idle_n;

    logic sck_meta;
    logic sck_sync;
    logic sck_prev;
    logic sck_rise_c;
    logic sck_fall_c;
    logic pd_hit_c;
    logic idle_hit_c;

    // Two-flop synchroniser for the asynchronous master clock, plus edge history
    always_ff @(posedge clk_50) begin
        if (rst) begin
            sck_meta <= 1'b0;
            sck_sync <= 1'b0;
            sck_prev <= 1'b0;
        end else begin
            sck_meta <= pd_sck;
            sck_sync <= sck_meta;
            sck_prev <= sck_sync;
        end
    end

    assign sck_rise_c = sck_sync & ~sck_prev;
    assign sck_fall_c = ~sck_sync & sck_prev;

    // State and datapath registers
    always_ff @(posedge clk_50) begin
        if (rst) begin
            state        <= ST_CONVERT;
            dout         <= 1'b1;
            gain_sel     <= 2'd0;
            frame_done   <= 1'b0;
            powered_down <= 1'b0;
            pending      <= '0;
            shift_q      <= '0;
            pulse_cnt    <= '0;
            conv_cnt     <= '0;
            hi_cnt       <= '0;
            idle_cnt     <= '0;
        end else begin
            state        <= state_n;
            dout         <= dout_n;
            gain_sel     <= gain_n;
            frame_done   <= done_n;
            powered_down <= pwrdn_n;
            pending      <= pending_n;
            shift_q      <= shift_n;
            pulse_cnt    <= pulse_n;
            conv_cnt     <= conv_n;
            hi_cnt       <= hi_n;
            idle_cnt     <= idle_n;
        end
    end

    // Next-state, counter and output decode
    always_comb begin
        state_n    = state;
        dout_n     = dout;
        gain_n     = gain_sel;
        done_n     = 1'b0;
        pending_n  = pending;
        shift_n    = shift_q;
        pulse_n    = pulse_cnt;
        conv_n     = conv_cnt;
        hi_n       = hi_cnt;
        idle_n     = idle_cnt;
        pd_hit_c   = 1'b0;
        idle_hit_c = 1'b0;

        // New samples are accepted in every state; the frame in flight uses shift_q
        if (sample_valid) begin
            pending_n = sample_data;
        end

        // Consecutive synced-high time; saturates so power-down holds while high
        if (sck_sync) begin
            if (hi_cnt == PD_LAST) begin
                pd_hit_c = 1'b1;
            end else begin
                hi_n = hi_cnt + PD_W'(1);
            end
        end else begin
            hi_n = '0;
        end

        // Consecutive synced-low time used to close a frame after the tail
        if (!sck_sync) begin
            if (idle_cnt == IDLE_LAST) begin
                idle_hit_c = 1'b1;
            end else begin
                idle_n = idle_cnt + IDLE_W'(1);
            end
        end else begin
            idle_n = '0;
        end

        case (state)
            ST_CONVERT: begin
                dout_n = 1'b1;
                conv_n = conv_cnt + CONV_W'(1);
                if (conv_cnt == CONV_LAST) begin
                    // pending_n so a coincident strobe is the value delivered
                    shift_n = pending_n;
                    conv_n  = '0;
                    dout_n  = 1'b0;
                    state_n = ST_READY;
                end
            end

            ST_READY: begin
                dout_n = 1'b0;
                if (sck_rise_c) begin
                    dout_n  = shift_q[DATA_W-1];
                    shift_n = {shift_q[DATA_W-2:0], 1'b0};
                    pulse_n = CNT_W'(1);
                    state_n = ST_SHIFT;
                end
            end

            ST_SHIFT: begin
                if (sck_rise_c) begin
                    pulse_n = pulse_cnt + CNT_W'(1);
                    if (pulse_cnt == PULSE_LAST_BIT) begin
                        dout_n  = 1'b1;
                        state_n = ST_TAIL;
                    end else begin
                        dout_n  = shift_q[DATA_W-1];
                        shift_n = {shift_q[DATA_W-2:0], 1'b0};
                    end
                end
            end

            ST_TAIL: begin
                dout_n = 1'b1;
                if (sck_rise_c && (pulse_cnt != PULSE_MAX)) begin
                    pulse_n = pulse_cnt + CNT_W'(1);
                end
                // Pulse 27 is the last meaningful one, so its falling edge ends the frame early
                if ((sck_fall_c && (pulse_cnt == PULSE_MAX)) || idle_hit_c) begin
                    gain_n  = 2'(pulse_cnt - PULSE_BASE);
                    done_n  = 1'b1;
                    conv_n  = '0;
                    pulse_n = '0;
                    state_n = ST_CONVERT;
                end
            end

            ST_PWRDN: begin
                dout_n = 1'b1;
                if (!sck_sync) begin
                    conv_n  = '0;
                    state_n = ST_CONVERT;
                end
            end

            default: begin
                dout_n  = 1'b1;
                conv_n  = '0;
                pulse_n = '0;
                state_n = ST_CONVERT;
            end
        endcase

        // Long high on pd_sck overrides everything else
        if (pd_hit_c) begin
            state_n = ST_PWRDN;
            dout_n  = 1'b1;
            gain_n  = 2'd0;
            pulse_n = '0;
            conv_n  = '0;
            done_n  = 1'b0;
        end

        pwrdn_n = (state_n == ST_PWRDN);
    end

endmodule

// File: tb/tb_hx711_slave.sv
// tb_hx711_slave: drives hx711_slave as an HX711 master would and checks
// frames through a scoreboard popped on every frame_done pulse.
module tb_hx711_slave;

    localparam int CONV = 600;
    localparam int PD   = 300;
    localparam int TAIL = 128;
    localparam int HI   = 32;
    localparam int LO   = 32;

    typedef struct packed {
        logic [23:0] data;
        logic [1:0]  gain;
    } exp_t;

    logic        clk_50 = 1'b0;
    logic        rst;
    logic        pd_sck;
    logic        dout;
    logic [23:0] sample_data;
    logic        sample_valid;
    logic [1:0]  gain_sel;
    logic        frame_done;
    logic        powered_down;

    exp_t        sb[$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;
    int          cyc_cnt = 0;
    int          done_cnt = 0;
    int          last_done_cyc = 0;
    int          last_fall_cyc = 0;
    logic [23:0] cap = '0;

    hx711_slave #(
        .CONV_CYCLES (CONV),
        .PD_CYCLES   (PD),
        .TAIL_IDLE   (TAIL)
    ) dut (
        .clk_50       (clk_50),
        .rst          (rst),
        .pd_sck       (pd_sck),
        .dout         (dout),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .gain_sel     (gain_sel),
        .frame_done   (frame_done),
        .powered_down (powered_down)
    );

    always #10 clk_50 = ~clk_50;

    always @(posedge clk_50) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc_cnt);
        end
    endtask

    // Monitor: every frame_done pops one expected frame
    always @(negedge clk_50) begin
        if (!rst && frame_done) begin
            done_cnt++;
            last_done_cyc = cyc_cnt;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_frame_done: got pulse expected none (cycle %0d)", cyc_cnt);
            end else begin
                mon_e = sb.pop_front();
                check("frame_data", 32'(cap), 32'(mon_e.data));
                check("frame_gain", 32'(gain_sel), 32'(mon_e.gain));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_50);
    endtask

    task automatic wait_fall(output int at);
        int n;
        n = 0;
        while (dout !== 1'b0 && n < 4 * CONV) begin
            step(1);
            n++;
        end
        at = cyc_cnt;
        if (dout !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL dout_fall_timeout: got dout=%b expected 0", dout);
        end
    endtask

    task automatic wait_done(input int prev);
        int n;
        n = 0;
        while (done_cnt == prev && n < 4 * CONV) begin
            step(1);
            n++;
        end
        if (done_cnt == prev) begin
            tests++;
            fails++;
            $display("FAIL frame_done_timeout: got none expected pulse");
        end
    endtask

    task automatic master_frame(input int np, input int strobe_at, input logic [23:0] strobe_val);
        cap = '0;
        for (int p = 1; p <= np; p++) begin
            pd_sck = 1'b1;
            step(HI);
            if (p <= 24) cap = {cap[22:0], dout};
            else check("tail_dout", 32'(dout), 32'd1);
            if (p == strobe_at) begin
                sample_data  = strobe_val;
                sample_valid = 1'b1;
                step(1);
                sample_valid = 1'b0;
            end
            pd_sck = 1'b0;
            last_fall_cyc = cyc_cnt;
            step(LO);
        end
    endtask

    task automatic run_frame(input int np, input logic [23:0] exp_data, input logic [1:0] exp_gain,
                             input int strobe_at, input logic [23:0] strobe_val);
        int prev;
        int t;
        wait_fall(t);
        sb.push_back(exp_t'({exp_data, exp_gain}));
        prev = done_cnt;
        master_frame(np, strobe_at, strobe_val);
        wait_done(prev);
    endtask

    initial begin
        step(80000);
        $display("FAIL watchdog: got no finish expected end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int mark;
        int prev;

        rst          = 1'b1;
        pd_sck       = 1'b0;
        sample_valid = 1'b0;
        sample_data  = '0;
        step(3);
        check("rst_dout",  32'(dout), 32'd1);
        check("rst_gain",  32'(gain_sel), 32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        check("rst_pwrdn", 32'(powered_down), 32'd0);
        rst  = 1'b0;
        mark = cyc_cnt;

        // Basic read
        sample_data  = 24'hA5C30F;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
        wait_fall(t);
        check("first_conv_len", 32'(t - mark), 32'(CONV));
        run_frame(25, 24'hA5C30F, 2'd0, 0, '0);
        check("idle_close_latency", 32'(last_done_cyc - last_fall_cyc), 32'(TAIL + 2));
        check("gain_after_25", 32'(gain_sel), 32'd0);
        wait_fall(t);
        check("conv_after_close", 32'(t - last_done_cyc), 32'(CONV));

        // Gain select
        run_frame(26, 24'hA5C30F, 2'd1, 0, '0);
        check("gain_after_26", 32'(gain_sel), 32'd1);
        run_frame(27, 24'hA5C30F, 2'd2, 0, '0);
        check("fall27_close_latency", 32'(last_done_cyc - last_fall_cyc), 32'd3);
        check("gain_after_27", 32'(gain_sel), 32'd2);

        // Sample update mid-frame
        sample_data  = 24'h000001;
        sample_valid = 1'b1;
        step(1);
        sample_valid = 1'b0;
        run_frame(25, 24'h000001, 2'd0, 10, 24'hFFFFFF);

        // Overflow pulses, which also delivers the strobed sample
        prev = done_cnt;
        run_frame(30, 24'hFFFFFF, 2'd2, 0, '0);
        step(100);
        check("one_done_for_30", 32'(done_cnt - prev), 32'd1);
        check("gain_after_30", 32'(gain_sel), 32'd2);

        // Power-down mid-shift
        wait_fall(t);
        master_frame(5, 0, '0);
        pd_sck = 1'b1;
        step(PD + 20);
        check("pd_powered_down", 32'(powered_down), 32'd1);
        check("pd_dout", 32'(dout), 32'd1);
        check("pd_gain", 32'(gain_sel), 32'd0);
        pd_sck = 1'b0;
        mark   = cyc_cnt;
        wait_fall(t);
        check("pd_exit_conv_len", 32'(t - mark), 32'(CONV + 3));
        check("pd_released", 32'(powered_down), 32'd0);

        // Reset mid-frame at pulse 12, after a frame that set gain 1
        run_frame(26, 24'hFFFFFF, 2'd1, 0, '0);
        wait_fall(t);
        for (int p = 1; p <= 12; p++) begin
            pd_sck = 1'b1;
            step(HI);
            if (p < 12) begin
                pd_sck = 1'b0;
                step(LO);
            end
        end
        rst    = 1'b1;
        pd_sck = 1'b0;
        mark   = cyc_cnt;
        step(1);
        rst = 1'b0;
        check("midrst_dout", 32'(dout), 32'd1);
        check("midrst_gain", 32'(gain_sel), 32'd0);
        check("midrst_pwrdn", 32'(powered_down), 32'd0);
        wait_fall(t);
        check("midrst_conv_len", 32'(t - mark), 32'(CONV + 1));
        run_frame(25, 24'h000000, 2'd0, 0, '0);

        step(10);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
